regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 85 ++++++++
 tb/tb_regfile_scoreboard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with a per-register busy scoreboard for tracking
// outstanding destination writes, with optional write-to-read forwarding.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_RPORTS-1:0]                  rbusy_o,
    input  logic [NUM_WPORTS-1:0]                  we_i,
    input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic                                   rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]                  rsv_addr_i,
    output logic                                   rsv_ready_o,
    input  logic                                   flush_i,
    output logic [NUM_WORDS-1:0]                   busy_o
);

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_WORDS-1:0]                 busy;
    logic                                 rsv_write_hit;
    logic                                 rsv_accept;

    // Ascending port scan so the highest-indexed matching writer is forwarded last.
    always_comb begin
        for (int r = 0; r < NUM_RPORTS; r++) begin
            rdata_o[r] = regs[raddr_i[r]];
            rbusy_o[r] = busy[raddr_i[r]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WPORTS; p++) begin
                    if (we_i[p] && (waddr_i[p] == raddr_i[r])) begin
                        rdata_o[r] = wdata_i[p];
                        rbusy_o[r] = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (raddr_i[r] == '0)) begin
                rdata_o[r] = '0;
            end
        end
    end

    always_comb begin
        rsv_write_hit = 1'b0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (we_i[p] && (waddr_i[p] == rsv_addr_i)) begin
                rsv_write_hit = 1'b1;
            end
        end
    end

    assign rsv_accept  = rsv_valid_i && (!busy[rsv_addr_i] || rsv_write_hit) && !flush_i;
    assign rsv_ready_o = rsv_accept;
    assign busy_o      = busy;

    // Statement order sets priority: writes clear busy, then a reservation re-sets
    // it, and a flush overrides every busy update but leaves data writes alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (we_i[p] && !((ZERO_REG != 0) && (waddr_i[p] == '0))) begin
                    regs[waddr_i[p]] <= wdata_i[p];
                    busy[waddr_i[p]] <= 1'b0;
                end
            end
            if (flush_i) begin
                busy <= '0;
            end else if (rsv_accept && !((ZERO_REG != 0) && (rsv_addr_i == '0))) begin
                busy[rsv_addr_i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; a second instance with
// forwarding disabled shares the same stimulus to check registered-only reads.
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NWORDS = 2 ** AW;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NR-1:0][AW-1:0]   raddr_i;
    logic [NR-1:0][DW-1:0]   rdata_o, rdata_nb;
    logic [NR-1:0]           rbusy_o, rbusy_nb;
    logic [NW-1:0]           we_i;
    logic [NW-1:0][AW-1:0]   waddr_i;
    logic [NW-1:0][DW-1:0]   wdata_i;
    logic                    rsv_valid_i;
    logic [AW-1:0]           rsv_addr_i;
    logic                    rsv_ready_o, rsv_ready_nb;
    logic                    flush_i;
    logic [NWORDS-1:0]       busy_o, busy_nb;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR),
                         .NUM_WPORTS(NW), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .rbusy_o(rbusy_o), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i), .rsv_ready_o(rsv_ready_o),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR),
                         .NUM_WPORTS(NW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_nb),
        .rbusy_o(rbusy_nb), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i), .rsv_ready_o(rsv_ready_nb),
        .flush_i(flush_i), .busy_o(busy_nb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then leave time for inputs/outputs to settle away from it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus();
        we_i        = '0;
        waddr_i     = '0;
        wdata_i     = '0;
        rsv_valid_i = 1'b0;
        rsv_addr_i  = '0;
        flush_i     = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        raddr_i = '0;
        applyStimulus();
        tick();
        tick();
        rst_i = 1'b0;

        raddr_i[0] = 5'd5;
        #1;
        checkOutput("rst_busy", busy_o, 32'h0);
        checkOutput("rst_rdata", rdata_o[0], 32'h0);
        checkOutput("rst_rbusy", {30'h0, rbusy_o}, 32'h0);
        checkOutput("rst_ready_idle", {31'h0, rsv_ready_o}, 32'h0);
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd3;
        #1;
        checkOutput("rst_ready_req", {31'h0, rsv_ready_o}, 32'h1);
        rsv_valid_i = 1'b0;

        // Write-then-read with and without forwarding
        we_i[0] = 1'b1; waddr_i[0] = 5'd5; wdata_i[0] = 32'hDEADBEEF;
        #1;
        checkOutput("wr_bypass_same", rdata_o[0], 32'hDEADBEEF);
        checkOutput("wr_nobypass_same", rdata_nb[0], 32'h0);
        tick();
        applyStimulus();
        #1;
        checkOutput("wr_next", rdata_o[0], 32'hDEADBEEF);
        checkOutput("wr_next_nb", rdata_nb[0], 32'hDEADBEEF);

        // Two ports collide on x7: port 1 wins
        we_i = 2'b11; waddr_i[0] = 5'd7; waddr_i[1] = 5'd7;
        wdata_i[0] = 32'h11; wdata_i[1] = 32'h22; raddr_i[1] = 5'd7;
        #1;
        checkOutput("coll_bypass", rdata_o[1], 32'h22);
        tick();
        applyStimulus();
        #1;
        checkOutput("coll_store", rdata_o[1], 32'h22);
        checkOutput("coll_store_nb", rdata_nb[1], 32'h22);

        // Scoreboard on x9
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd9; raddr_i[0] = 5'd9;
        #1;
        checkOutput("rsv9_ready", {31'h0, rsv_ready_o}, 32'h1);
        tick();
        rsv_valid_i = 1'b0;
        #1;
        checkOutput("rsv9_busy", busy_o, 32'h0000_0200);
        checkOutput("rsv9_rbusy", {31'h0, rbusy_o[0]}, 32'h1);
        rsv_valid_i = 1'b1;
        #1;
        checkOutput("rsv9_again", {31'h0, rsv_ready_o}, 32'h0);
        we_i[0] = 1'b1; waddr_i[0] = 5'd9; wdata_i[0] = 32'h55;
        #1;
        checkOutput("rsv9_wr_ready", {31'h0, rsv_ready_o}, 32'h1);
        checkOutput("rsv9_wr_rbusy", {31'h0, rbusy_o[0]}, 32'h0);
        checkOutput("rsv9_wr_rdata", rdata_o[0], 32'h55);
        checkOutput("rsv9_wr_rbusy_nb", {31'h0, rbusy_nb[0]}, 32'h1);
        tick();
        applyStimulus();
        #1;
        checkOutput("rsv9_wins", busy_o, 32'h0000_0200);
        checkOutput("rsv9_data", rdata_o[0], 32'h55);
        we_i[0] = 1'b1; waddr_i[0] = 5'd9; wdata_i[0] = 32'h56;
        tick();
        applyStimulus();
        #1;
        checkOutput("wr9_clears", busy_o, 32'h0);

        // Zero register
        we_i[0] = 1'b1; waddr_i[0] = 5'd0; wdata_i[0] = 32'hFFFF;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd0; raddr_i[0] = 5'd0;
        #1;
        checkOutput("x0_rdata_same", rdata_o[0], 32'h0);
        checkOutput("x0_ready", {31'h0, rsv_ready_o}, 32'h1);
        tick();
        applyStimulus();
        #1;
        checkOutput("x0_busy", busy_o, 32'h0);
        checkOutput("x0_rdata", rdata_o[0], 32'h0);
        checkOutput("x0_rdata_nb", rdata_nb[0], 32'h0);

        // Flush with a competing reservation and an unaffected data write
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        tick();
        rsv_addr_i = 5'd4;
        tick();
        applyStimulus();
        #1;
        checkOutput("busy_3_4", busy_o, 32'h0000_0018);
        flush_i = 1'b1; rsv_valid_i = 1'b1; rsv_addr_i = 5'd6;
        we_i[0] = 1'b1; waddr_i[0] = 5'd10; wdata_i[0] = 32'hAB;
        #1;
        checkOutput("flush_ready", {31'h0, rsv_ready_o}, 32'h0);
        tick();
        applyStimulus();
        raddr_i[0] = 5'd10;
        #1;
        checkOutput("flush_busy", busy_o, 32'h0);
        checkOutput("flush_data", rdata_o[0], 32'hAB);

        // Reset in the middle of a write and with a reservation pending
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd12;
        tick();
        applyStimulus();
        #1;
        checkOutput("busy_12", busy_o, 32'h0000_1000);
        rst_i = 1'b1;
        we_i[0] = 1'b1; waddr_i[0] = 5'd8; wdata_i[0] = 32'h1;
        tick();
        rst_i = 1'b0;
        applyStimulus();
        raddr_i[0] = 5'd8; raddr_i[1] = 5'd5;
        #1;
        checkOutput("rst_x8", rdata_o[0], 32'h0);
        checkOutput("rst_x5", rdata_o[1], 32'h0);
        checkOutput("rst_busy_clr", busy_o, 32'h0);
        checkOutput("rst_busy_clr_nb", busy_nb, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
